// File: rtl/text_line_renderer.sv
// Text-mode line renderer: walks one text row of the character map, fetches
// each glyph byte from a registered 1bpp ROM and expands it into eight palette
// indices written to the line buffer.
module text_line_renderer #(
  parameter int MAP_COLS   = 80,
  parameter int ROW_STRIDE = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start,
  input  logic [8:0]  line_y,
  input  logic [16:0] map_base,
  input  logic        charset_hi,
  output logic [16:0] map_addr,
  output logic        map_strobe,
  input  logic        map_ack,
  input  logic [15:0] map_data,
  output logic [11:0] char_rom_addr,
  input  logic [7:0]  char_rom_data,
  output logic        lb_wr_en,
  output logic [9:0]  lb_wr_addr,
  output logic [7:0]  lb_wr_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, MAP_REQ, GLYPH_WAIT, PIXELS} state_t;

  localparam logic [6:0] LAST_COL = 7'(MAP_COLS - 1);

  state_t      state_q, state_d;
  logic [5:0]  row_q, row_d;          // text row of the line being rendered
  logic [2:0]  grow_q, grow_d;        // glyph scanline within the text row
  logic [16:0] base_q, base_d;
  logic        cs_q, cs_d;
  logic [6:0]  col_q, col_d;
  logic [2:0]  px_q, px_d;
  logic [3:0]  fg_q, fg_d, bg_q, bg_d;
  logic [11:0] rom_addr_q, rom_addr_d;
  logic [7:0]  wdata_q, wdata_d;      // last written pixel, held while not writing
  logic        done_q, done_d;

  logic [16:0] row_off;
  logic [7:0]  pix_data;

  // Map address is derived from the latched line parameters; 17-bit sum wraps.
  assign row_off  = 17'(row_q) * 17'(ROW_STRIDE);
  assign map_addr = base_q + row_off + {10'd0, col_q};

  // Glyph bit 7 is the leftmost pixel, so pixel px reads bit 7-px.
  assign pix_data = {4'h0, char_rom_data[3'd7 - px_q] ? fg_q : bg_q};

  assign map_strobe    = (state_q == MAP_REQ);
  assign lb_wr_en      = (state_q == PIXELS);
  assign lb_wr_addr    = {col_q, px_q};
  assign lb_wr_data    = (state_q == PIXELS) ? pix_data : wdata_q;
  assign char_rom_addr = rom_addr_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

  // Next-state and datapath: one character per MAP_REQ/GLYPH_WAIT/PIXELS pass.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    grow_d     = grow_q;
    base_d     = base_q;
    cs_d       = cs_q;
    col_d      = col_q;
    px_d       = px_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    rom_addr_d = rom_addr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_start) begin
          row_d   = line_y[8:3];
          grow_d  = line_y[2:0];
          base_d  = map_base;
          cs_d    = charset_hi;
          col_d   = 7'd0;
          px_d    = 3'd0;
          state_d = MAP_REQ;
        end
      end
      MAP_REQ: begin
        if (map_ack) begin
          fg_d       = map_data[11:8];
          bg_d       = map_data[15:12];
          rom_addr_d = {cs_q, map_data[7:0], grow_q};
          px_d       = 3'd0;
          state_d    = GLYPH_WAIT;
        end
      end
      GLYPH_WAIT: state_d = PIXELS;
      PIXELS: begin
        wdata_d = pix_data;
        if (px_q == 3'd7) begin
          if (col_q == LAST_COL) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            col_d   = 7'(col_q + 7'd1);
            state_d = MAP_REQ;
          end
        end else begin
          px_d = 3'(px_q + 3'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset clears everything so outputs read zero immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      grow_q     <= '0;
      base_q     <= '0;
      cs_q       <= 1'b0;
      col_q      <= '0;
      px_q       <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      rom_addr_q <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      grow_q     <= grow_d;
      base_q     <= base_d;
      cs_q       <= cs_d;
      col_q      <= col_d;
      px_q       <= px_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      rom_addr_q <= rom_addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_text_line_renderer.sv
// Scoreboard bench for text_line_renderer: a map RAM responder with random or
// fixed ack delay, a registered glyph ROM model, and a monitor that pops the
// expected line-buffer writes produced by a reference model of the line.
module tb_text_line_renderer;
  localparam int COLS = 80;

  logic        clk = 1'b0, rst = 1'b1, line_start = 1'b0, charset_hi = 1'b0;
  logic [8:0]  line_y = '0;
  logic [16:0] map_base = '0;
  logic        map_ack = 1'b0;
  logic [15:0] map_data = '0;
  logic [7:0]  char_rom_data = '0;
  logic [16:0] map_addr;
  logic        map_strobe, lb_wr_en, busy, done;
  logic [11:0] char_rom_addr;
  logic [9:0]  lb_wr_addr;
  logic [7:0]  lb_wr_data;

  text_line_renderer #(.MAP_COLS(COLS), .ROW_STRIDE(128)) u_dut (
    .clk(clk), .rst(rst), .line_start(line_start), .line_y(line_y),
    .map_base(map_base), .charset_hi(charset_hi), .map_addr(map_addr),
    .map_strobe(map_strobe), .map_ack(map_ack), .map_data(map_data),
    .char_rom_addr(char_rom_addr), .char_rom_data(char_rom_data),
    .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  logic [15:0] mem [131072];
  logic [7:0]  rom [4096];

  typedef struct {
    logic [9:0]  a;
    logic [7:0]  d;
    logic [11:0] ra;
    bit          first;
    bit          last;
  } wr_t;

  wr_t         wq[$];
  logic [16:0] mq[$];
  logic [16:0] acked[$];
  logic [7:0]  cap[$];
  logic [11:0] first_rom = '0;
  int checks = 0, errors = 0;
  int dly_fixed = -1, cnt = 0;
  bit armed = 0, spur = 0, exp_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Registered glyph ROM, one cycle of latency.
  always @(posedge clk) char_rom_data <= rom[char_rom_addr];

  // Map RAM responder: acks after a delay, checks the address stays put,
  // optionally injects acks while no request is pending.
  always @(negedge clk) begin
    map_ack = 1'b0;
    if (rst) armed = 0;
    else if (map_strobe) begin
      if (!armed) begin
        cnt   = (dly_fixed >= 0) ? dly_fixed : int'($urandom_range(0, 7));
        armed = 1;
        chk("map_req_expected", 32'(mq.size() != 0), 1);
      end
      if (mq.size() > 0) chk("map_addr", map_addr, mq[0]);
      if (cnt == 0) begin
        map_ack  = 1'b1;
        map_data = mem[map_addr];
        acked.push_back(map_addr);
        if (mq.size() > 0) void'(mq.pop_front());
        armed = 0;
      end else cnt--;
    end else if (spur && $urandom_range(0, 3) == 0) begin
      map_ack  = 1'b1;
      map_data = 16'($urandom);
    end
  end

  // Monitor: compares every line-buffer write and the done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      chk("done", done, exp_done);
      if (exp_done) chk("busy_at_done", busy, 0);
      exp_done = 0;
      if (lb_wr_en) begin
        if (wq.size() == 0) chk("extra_write", lb_wr_en, 0);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("lb_wr_addr", lb_wr_addr, w.a);
          chk("lb_wr_data", lb_wr_data, w.d);
          chk("busy_writing", busy, 1);
          if (w.first) begin
            chk("char_rom_addr", char_rom_addr, w.ra);
            if (w.a == 0) first_rom = char_rom_addr;
          end
          cap.push_back(lb_wr_data);
          if (w.last) exp_done = 1;
        end
      end
    end
  end

  // Reference model: what one full line must write, from the map/ROM contents.
  task automatic expect_line(input logic [8:0] y, input logic [16:0] b, input logic cs);
    for (int c = 0; c < COLS; c++) begin
      logic [16:0] a;
      logic [15:0] w;
      logic [11:0] ra;
      logic [7:0]  g;
      a  = 17'((int'(b) + int'(y[8:3]) * 128 + c) % 131072);
      w  = mem[a];
      ra = {cs, w[7:0], y[2:0]};
      g  = rom[ra];
      mq.push_back(a);
      for (int p = 0; p < 8; p++) begin
        wr_t e;
        e.a = 10'(c * 8 + p);
        e.d = {4'h0, g[7-p] ? w[11:8] : w[15:12]};
        e.ra = ra;
        e.first = (p == 0);
        e.last = (c == COLS - 1) && (p == 7);
        wq.push_back(e);
      end
    end
  endtask

  task automatic run_line(input logic [8:0] y, input logic [16:0] b, input logic cs,
                          input int d, input bit mid, output int cyc);
    dly_fixed = d;
    acked.delete();
    cap.delete();
    expect_line(y, b, cs);
    @(posedge clk); #1;
    line_y = y; map_base = b; charset_hi = cs; line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    chk("busy_after_start", busy, 1);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (mid && cyc == 100) begin
        line_start = 1'b1; line_y = 9'($urandom); map_base = 17'($urandom);
        charset_hi = ~cs;
      end
      if (mid && cyc == 101) line_start = 1'b0;
      if (done) break;
      if (cyc > 3000) begin
        chk("line_timeout", 1, 0);
        break;
      end
    end
    @(negedge clk);
    chk("writes_left", wq.size(), 0);
    chk("reqs_left", mq.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_map_strobe", map_strobe, 0);
    chk("rst_lb_wr_en", lb_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_map_addr", map_addr, 0);
    chk("rst_char_rom_addr", char_rom_addr, 0);
    chk("rst_lb_wr_addr", lb_wr_addr, 0);
    chk("rst_lb_wr_data", lb_wr_data, 0);
  endtask

  initial begin
    int cyc;
    int tab [8] = '{1, 2, 1, 2, 2, 1, 2, 1};
    for (int i = 0; i < 131072; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    for (int i = 128; i < 128 + COLS; i++) mem[i] = 16'h2141;
    rom[12'h20A] = 8'hA5;
    mem[17'h1FFFF] = 16'h34FF;

    repeat (3) @(posedge clk);
    #1 chk_reset_outputs();
    rst = 1'b0;

    // Directed line with immediate acks, then fixed ack delays.
    run_line(9'd10, 17'd0, 1'b0, 0, 0, cyc);
    chk("t1_first_map_addr", acked[0], 128);
    chk("t1_first_rom_addr", first_rom, 12'h20A);
    for (int i = 0; i < 8; i++) chk("t1_pixel", cap[i], tab[i]);
    chk("t1_cycles", cyc, COLS * 10 + 1);
    for (int k = 0; k < 2; k++) begin
      int d = (k == 0) ? 3 : 7;
      run_line(9'd10, 17'd0, 1'b0, d, 0, cyc);
      chk("t2_cycles", cyc, COLS * (d + 10) + 1);
      chk("t2_pixel0", cap[0], 1);
    end

    // Full line over random map contents and random ack delays.
    run_line(9'd77, 17'h0ABCD, 1'b0, -1, 0, cyc);
    chk("t3_write_count", cap.size(), COLS * 8);

    // Bank select, last glyph row, map address wrap.
    run_line(9'd7, 17'h1FFFF, 1'b1, -1, 0, cyc);
    chk("t4_rom_addr", first_rom, 12'hFFF);
    chk("t4_addr0", acked[0], 17'h1FFFF);
    chk("t4_addr1_wrap", acked[1], 0);

    // Same as the random full line with a mid-line restart and stray acks.
    spur = 1;
    run_line(9'd77, 17'h0ABCD, 1'b0, -1, 1, cyc);
    chk("t5_write_count", cap.size(), COLS * 8);
    spur = 0;

    // Reset during PIXELS of column 5.
    dly_fixed = -1;
    expect_line(9'd200, 17'h01234, 1'b1);
    @(posedge clk); #1;
    line_y = 9'd200; map_base = 17'h01234; charset_hi = 1'b1; line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    cyc = 0;
    while (!(lb_wr_en && lb_wr_addr == 10'd43) && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t6_reached_col5", 32'(cyc < 1000), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs();
    rst = 1'b0;
    wq.delete(); mq.delete(); exp_done = 0;
    repeat (5) @(posedge clk);
    #1 chk("t6_idle", busy, 0);
    run_line(9'd200, 17'h01234, 1'b1, -1, 0, cyc);
    chk("t6_write_count", cap.size(), COLS * 8);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
